pwd_lock_ctrl: RTL
==================

# pwd_lock_ctrl

Sequencing controller for the 4-bit toggle-based password storage (TFF storage bank). It checks entered codes against the stored password and counts failed attempts. It enforces an alarm lockout and reprograms the stored password by driving one-cycle toggle masks, then verifies the write. It sits between the keypad/entry logic and the password storage register.

## Interface
Parameters:
- MAX_TRIES, 3, failed attempts that trigger lockout; legal range 1..3.
- LOCKOUT_CYCLES, 16, cycles `alarm` stays high; ≥1.
- UNLOCK_CYCLES, 32, cycles `unlocked` stays high without relock; ≥1.

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- code_in  in  4  entered code; sampled only in cycles where `enter` or `prog_req` is accepted.
- enter  in  1  one-cycle entry strobe.
- prog_req  in  1  one-cycle request to program `code_in` as the new password.
- store_q  in  4  current stored password, read back from the storage outputs.
- t_out  out  4  toggle mask to the storage T inputs; zero except during the write cycle.
- unlocked  out  1  high while in UNLOCKED.
- alarm  out  1  high while in LOCKOUT.
- prog_done  out  1  one-cycle pulse after a verified password write.
- fail_cnt  out  2  consecutive failed attempts.

## Operation
- States: LOCKED, UNLOCKED, PROG_WRITE, PROG_VERIFY, LOCKOUT.
- Reset (rst=0, asynchronous) forces:
  - state = LOCKED;
  - t_out = 0, unlocked = 0, alarm = 0, prog_done = 0, fail_cnt = 0;
  - timers = 0.
  - The controller does not reset the storage itself.
- LOCKED, when `enter` is accepted:
  - If code_in == store_q, go to UNLOCKED, fail_cnt ← 0, unlock timer ← UNLOCK_CYCLES−1.
  - Otherwise fail_cnt ← fail_cnt+1.
  - If that increment reaches MAX_TRIES, go to LOCKOUT instead; lockout timer ← LOCKOUT_CYCLES−1.
  - `prog_req` is ignored in LOCKED.
- UNLOCKED, with the timer decrementing each cycle:
  - `prog_req` takes priority over `enter` and over timer expiry. It captures new_code ← code_in, sets t_out ← code_in ^ store_q, and moves to PROG_WRITE.
  - Otherwise, `enter` relocks immediately and goes to LOCKED.
  - Otherwise, timer == 0 goes to LOCKED.
- PROG_WRITE (exactly one cycle): t_out holds the mask and the storage toggles at the closing edge. At that edge t_out ← 0 and the state moves to PROG_VERIFY.
- PROG_VERIFY (exactly one cycle):
  - If store_q == new_code, assert prog_done for the next cycle and go to LOCKED with fail_cnt ← 0.
  - On mismatch, go to LOCKOUT (alarm) with the lockout timer loaded.
- LOCKOUT: `enter` and `prog_req` are ignored. The timer decrements; at 0 the state goes to LOCKED and fail_cnt ← 0.
- All outputs are registered or decoded from the state register; none are combinational from inputs.
- t_out is nonzero only in PROG_WRITE. A mask of 0 is legal when the new code equals the stored code; verify still runs.

## Timing
- Unlock: `enter` with a matching code in cycle M gives unlocked = 1 for cycles M+1 .. M+UNLOCK_CYCLES, then 0.
- Failed attempt: fail_cnt updates in cycle M+1. On the lockout transition, alarm = 1 for exactly LOCKOUT_CYCLES cycles starting at M+1.
- Program: `prog_req` accepted in cycle N gives:
  - t_out ≠ 0 in N+1;
  - store_q updated in N+2 (verify cycle);
  - prog_done = 1 in N+3, state LOCKED.
  - unlocked = 0 from N+1.
- `prog_req` on the final UNLOCKED cycle (timer 0) is still accepted.
- Back-to-back `enter` strobes are each evaluated. No entry is lost except in LOCKOUT, PROG_WRITE and PROG_VERIFY, where entries are dropped.
- Reset asserted mid PROG_WRITE clears t_out immediately (asynchronously). A partial toggle cannot occur after rst falls.

## Test plan
- Reset, then with store_q = 4'hA: enter, code 4'hA → unlocked high exactly 32 cycles, fail_cnt = 0, t_out = 0 throughout.
- store_q = 4'hA: three enters with 4'h3 → fail_cnt 1, 2, then alarm high exactly 16 cycles. Enters during the alarm are ignored; afterwards fail_cnt = 0 and state LOCKED.
- While unlocked with store_q = 4'hA: prog_req with code 4'h5 → t_out = 4'hF for one cycle, store_q = 4'h5, prog_done pulse 2 cycles after the mask, then enter 4'h5 unlocks.
- Same cycle `prog_req` and `enter` while unlocked → programming path taken, no relock. With new code equal to stored code → t_out = 0 and prog_done still pulses.
- Fault injection: storage model ignores T during the write → verify mismatch → alarm high 16 cycles, prog_done never asserted.
- rst driven low during PROG_WRITE with t_out = 4'h6 → t_out = 0, all outputs 0 without a clock edge. After release the state is LOCKED.

Source files
------------

// File: rtl/pwd_lock_ctrl_if.sv
// Keypad/storage-side signal bundle for the password lock controller.
// The controller uses the slave modport; the entry logic or bench uses master.
interface pwd_lock_ctrl_if;
    logic [3:0] code_in;
    logic       enter;
    logic       prog_req;
    logic [3:0] store_q;
    logic [3:0] t_out;
    logic       unlocked;
    logic       alarm;
    logic       prog_done;
    logic [1:0] fail_cnt;

    modport master (
        output code_in, enter, prog_req, store_q,
        input  t_out, unlocked, alarm, prog_done, fail_cnt
    );

    modport slave (
        input  code_in, enter, prog_req, store_q,
        output t_out, unlocked, alarm, prog_done, fail_cnt
    );
endinterface

// File: rtl/pwd_lock_ctrl.sv
// Password check / lockout / reprogram sequencer for a 4-bit toggle-flop password bank.
// Writes are one-cycle T masks followed by a read-back verify.
//
//   state         | meaning
//   S_LOCKED      | idle, evaluating enter strobes against the stored code
//   S_UNLOCKED    | access granted, unlock timer running
//   S_PROG_WRITE  | toggle mask driven to the storage for this single cycle
//   S_PROG_VERIFY | storage read back and compared with the new code
//   S_LOCKOUT     | alarm raised, lockout timer running, inputs ignored
module pwd_lock_ctrl #(
    parameter int MAX_TRIES      = 3,
    parameter int LOCKOUT_CYCLES = 16,
    parameter int UNLOCK_CYCLES  = 32
) (
    input  logic           clk,
    input  logic           rst,
    pwd_lock_ctrl_if.slave bus
);
    localparam int MAX_CYC = (LOCKOUT_CYCLES > UNLOCK_CYCLES) ? LOCKOUT_CYCLES : UNLOCK_CYCLES;
    localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [TW-1:0] LOCK_LOAD   = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [TW-1:0] UNLOCK_LOAD = TW'(UNLOCK_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_ONE   = TW'(1);
    localparam logic [1:0]    TRIES       = 2'(MAX_TRIES);

    typedef enum logic [2:0] {
        S_LOCKED,
        S_UNLOCKED,
        S_PROG_WRITE,
        S_PROG_VERIFY,
        S_LOCKOUT
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [1:0]    fail_cnt_q, fail_cnt_d;
    logic [3:0]    new_code_q, new_code_d;
    logic [3:0]    t_out_q, t_out_d;
    logic          prog_done_q, prog_done_d;
    logic [1:0]    fail_inc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_LOCKED;
            timer_q     <= '0;
            fail_cnt_q  <= '0;
            new_code_q  <= '0;
            t_out_q     <= '0;
            prog_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            fail_cnt_q  <= fail_cnt_d;
            new_code_q  <= new_code_d;
            t_out_q     <= t_out_d;
            prog_done_q <= prog_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        fail_cnt_d  = fail_cnt_q;
        new_code_d  = new_code_q;
        t_out_d     = '0;
        prog_done_d = 1'b0;
        fail_inc    = fail_cnt_q + 2'd1;

        case (state_q)
            S_LOCKED: begin
                if (bus.enter) begin
                    if (bus.code_in == bus.store_q) begin
                        state_d    = S_UNLOCKED;
                        fail_cnt_d = '0;
                        timer_d    = UNLOCK_LOAD;
                    end else begin
                        fail_cnt_d = fail_inc;
                        if (fail_inc == TRIES) begin
                            state_d = S_LOCKOUT;
                            timer_d = LOCK_LOAD;
                        end
                    end
                end
            end
            S_UNLOCKED: begin
                timer_d = timer_q - TIMER_ONE;
                // Programming wins even on the last unlocked cycle.
                if (bus.prog_req) begin
                    new_code_d = bus.code_in;
                    t_out_d    = bus.code_in ^ bus.store_q;
                    state_d    = S_PROG_WRITE;
                    timer_d    = '0;
                end else if (bus.enter || (timer_q == '0)) begin
                    state_d = S_LOCKED;
                    timer_d = '0;
                end
            end
            S_PROG_WRITE: begin
                state_d = S_PROG_VERIFY;
            end
            S_PROG_VERIFY: begin
                if (bus.store_q == new_code_q) begin
                    prog_done_d = 1'b1;
                    fail_cnt_d  = '0;
                    state_d     = S_LOCKED;
                end else begin
                    state_d = S_LOCKOUT;
                    timer_d = LOCK_LOAD;
                end
            end
            S_LOCKOUT: begin
                if (timer_q == '0) begin
                    state_d    = S_LOCKED;
                    fail_cnt_d = '0;
                end else begin
                    timer_d = timer_q - TIMER_ONE;
                end
            end
            default: begin
                state_d = S_LOCKED;
                timer_d = '0;
            end
        endcase
    end

    assign bus.t_out     = t_out_q;
    assign bus.unlocked  = (state_q == S_UNLOCKED);
    assign bus.alarm     = (state_q == S_LOCKOUT);
    assign bus.prog_done = prog_done_q;
    assign bus.fail_cnt  = fail_cnt_q;
endmodule
